// File: rtl/fb_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fb_sched_pkg
// Purpose  : Shared types, constants and the slot address helper for the
//            triple-buffer frame scheduler.
// Contents : fb_state_t  - scheduler FSM states (2-bit encoding)
//            SLOT_W      - width of a slot index
//            DEF_*       - default slot-0 address and slot stride
//            slot_addr() - base + idx * stride
// Revision : 1.0 - initial release
// ============================================================================
package fb_sched_pkg;

  localparam int SLOT_W = 2;

  localparam logic [31:0] DEF_BASE_ADDR    = 32'h0100_0000;
  localparam logic [31:0] DEF_FRAME_STRIDE = 32'h0010_0000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } fb_state_t;

  // Computed at 64 bits so any address width up to 64 can truncate the result.
  function automatic logic [63:0] slot_addr(
    input logic [SLOT_W-1:0] idx,
    input logic [63:0]       base   = 64'(DEF_BASE_ADDR),
    input logic [63:0]       stride = 64'(DEF_FRAME_STRIDE)
  );
    return base + (64'(idx) * stride);
  endfunction

endpackage
`default_nettype wire

// File: rtl/frame_buffer_scheduler_sync_edge_detect.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_detect
// Purpose  : Brings an asynchronous level into the clk domain through
//            STAGES flops and emits a registered one-cycle pulse on each
//            rising edge. The pulse is high STAGES+1 cycles after the edge.
// Ports    : clk   in  1  destination clock
//            rst   in  1  asynchronous active-high reset
//            din   in  1  asynchronous level
//            pulse out 1  single-cycle rising-edge pulse
// Revision : 1.0 - initial release
// ============================================================================
module sync_edge_detect #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              pulse_q;

  generate
    if (STAGES > 1) begin : g_multi_stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[STAGES-2:0], din};
      end
    end else begin : g_single_stage
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= din;
      end
    end
  endgenerate

  // prev_q trails the last sync stage by one cycle; the pulse is registered
  // so downstream logic sees a clean flop output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      prev_q  <= sync_q[STAGES-1];
      pulse_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign pulse = pulse_q;

endmodule
`default_nettype wire

// File: rtl/frame_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_buffer_scheduler
// Purpose  : Triple-buffer controller for the DDR frame store. Rotates three
//            frame slots between writer, spare and reader so the writer
//            always owns a free slot and the reader a complete frame.
// Ports    : clk_100Mhz     in   system clock
//            rst            in   asynchronous active-high reset
//            enable         in   scheduler run enable
//            frame_done     in   writer frame-end level (asynchronous)
//            rd_vsync       in   reader frame-start level (asynchronous)
//            wr_base_addr   out  writer frame base address
//            rd_base_addr   out  reader frame base address
//            wr_idx/rd_idx  out  slots owned by writer / reader
//            rd_frame_valid out  reader holds a completed frame
//            swap_pulse     out  one cycle on a reader slot change
//            frame_cnt      out  completed writer frames
//            drop_cnt       out  frames overwritten before being read
//            state          out  FSM state (debug)
// Options  : FB_SCHED_STATS_EN - builds frame_cnt/drop_cnt; otherwise both
//            outputs are tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module frame_buffer_scheduler
  import fb_sched_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(DEF_BASE_ADDR),
  parameter logic [ADDR_WIDTH-1:0] FRAME_STRIDE = ADDR_WIDTH'(DEF_FRAME_STRIDE),
  parameter int                    SYNC_STAGES  = 2
) (
  input  logic                  clk_100Mhz,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  frame_done,
  input  logic                  rd_vsync,
  output logic [ADDR_WIDTH-1:0] wr_base_addr,
  output logic [ADDR_WIDTH-1:0] rd_base_addr,
  output logic [SLOT_W-1:0]     wr_idx,
  output logic [SLOT_W-1:0]     rd_idx,
  output logic                  rd_frame_valid,
  output logic                  swap_pulse,
  output logic [15:0]           frame_cnt,
  output logic [15:0]           drop_cnt,
  output logic [1:0]            state
);

  logic wr_ev;
  logic rd_ev;

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_wr_sync (
    .clk   (clk_100Mhz),
    .rst   (rst),
    .din   (frame_done),
    .pulse (wr_ev)
  );

  sync_edge_detect #(.STAGES(SYNC_STAGES)) u_rd_sync (
    .clk   (clk_100Mhz),
    .rst   (rst),
    .din   (rd_vsync),
    .pulse (rd_ev)
  );

  fb_state_t         state_q, state_d;
  logic [SLOT_W-1:0] w_idx_q, w_idx_d;
  logic [SLOT_W-1:0] l_idx_q, l_idx_d;
  logic [SLOT_W-1:0] r_idx_q, r_idx_d;
  logic              new_q, new_d;
  logic              valid_q, valid_d;
  logic              swap_q, swap_d;
  logic              inc_frame;
  logic              inc_drop;

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_idx_q <= 2'd0;
      l_idx_q <= 2'd1;
      r_idx_q <= 2'd2;
      new_q   <= 1'b0;
      valid_q <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_idx_q <= w_idx_d;
      l_idx_q <= l_idx_d;
      r_idx_q <= r_idx_d;
      new_q   <= new_d;
      valid_q <= valid_d;
      swap_q  <= swap_d;
    end
  end

  // Every transition is a permutation of {w,l,r}, so the three indices stay
  // distinct by construction.
  always_comb begin
    state_d   = state_q;
    w_idx_d   = w_idx_q;
    l_idx_d   = l_idx_q;
    r_idx_d   = r_idx_q;
    new_d     = new_q;
    valid_d   = valid_q;
    swap_d    = 1'b0;
    inc_frame = 1'b0;
    inc_drop  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) state_d = valid_q ? S_RUN : S_FILL;
      end

      S_FILL: begin
        if (wr_ev) begin
          w_idx_d   = l_idx_q;
          l_idx_d   = w_idx_q;
          new_d     = 1'b1;
          inc_frame = 1'b1;
          state_d   = S_RUN;
        end
      end

      S_RUN: begin
        if (wr_ev && rd_ev) begin
          // Reader takes the frame that just completed; any unread spare
          // is discarded.
          r_idx_d   = w_idx_q;
          w_idx_d   = l_idx_q;
          l_idx_d   = r_idx_q;
          new_d     = 1'b0;
          valid_d   = 1'b1;
          swap_d    = 1'b1;
          inc_frame = 1'b1;
          inc_drop  = new_q;
        end else if (wr_ev) begin
          w_idx_d   = l_idx_q;
          l_idx_d   = w_idx_q;
          new_d     = 1'b1;
          inc_frame = 1'b1;
          inc_drop  = new_q;
        end else if (rd_ev && new_q) begin
          r_idx_d = l_idx_q;
          l_idx_d = r_idx_q;
          new_d   = 1'b0;
          valid_d = 1'b1;
          swap_d  = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Events seen in this cycle were already applied above.
    if (!enable) state_d = S_IDLE;
  end

`ifdef FB_SCHED_STATS_EN
  logic [15:0] frame_cnt_q;
  logic [15:0] drop_cnt_q;

  always_ff @(posedge clk_100Mhz or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= 16'd0;
      drop_cnt_q  <= 16'd0;
    end else begin
      if (inc_frame) frame_cnt_q <= frame_cnt_q + 16'd1;
      if (inc_drop)  drop_cnt_q  <= drop_cnt_q + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign drop_cnt  = drop_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = inc_frame ^ inc_drop;
  assign frame_cnt    = 16'd0;
  assign drop_cnt     = 16'd0;
`endif

  assign wr_base_addr   = ADDR_WIDTH'(slot_addr(w_idx_q, 64'(BASE_ADDR), 64'(FRAME_STRIDE)));
  assign rd_base_addr   = ADDR_WIDTH'(slot_addr(r_idx_q, 64'(BASE_ADDR), 64'(FRAME_STRIDE)));
  assign wr_idx         = w_idx_q;
  assign rd_idx         = r_idx_q;
  assign rd_frame_valid = valid_q;
  assign swap_pulse     = swap_q;
  assign state          = state_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_buffer_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_buffer_scheduler
// Purpose  : Directed self-checking bench for frame_buffer_scheduler. Reader
//            swaps are predicted into a queue and checked by a monitor on
//            each swap_pulse; other state is checked directly.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_buffer_scheduler;

`ifdef FB_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_100Mhz = 1'b0;
  logic        rst        = 1'b1;
  logic        enable     = 1'b0;
  logic        frame_done = 1'b0;
  logic        rd_vsync   = 1'b0;
  logic [31:0] wr_base_addr, rd_base_addr;
  logic [1:0]  wr_idx, rd_idx, state;
  logic        rd_frame_valid, swap_pulse;
  logic [15:0] frame_cnt, drop_cnt;

  frame_buffer_scheduler dut (
    .clk_100Mhz     (clk_100Mhz),
    .rst            (rst),
    .enable         (enable),
    .frame_done     (frame_done),
    .rd_vsync       (rd_vsync),
    .wr_base_addr   (wr_base_addr),
    .rd_base_addr   (rd_base_addr),
    .wr_idx         (wr_idx),
    .rd_idx         (rd_idx),
    .rd_frame_valid (rd_frame_valid),
    .swap_pulse     (swap_pulse),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt),
    .state          (state)
  );

  always #5 clk_100Mhz = ~clk_100Mhz;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] addr;
  } swap_t;

  swap_t sb_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] cnt(input int v);
    return STATS ? 16'(v) : 16'd0;
  endfunction

  // Monitor: every swap_pulse must match the oldest predicted swap and last
  // exactly one cycle.
  logic prev_swap = 1'b0;
  always @(negedge clk_100Mhz) begin
    if (rst) begin
      prev_swap <= 1'b0;
    end else begin
      if (swap_pulse) begin
        check("swap_width", {63'd0, prev_swap}, 64'd0);
        if (sb_q.size() == 0) begin
          check("swap_unexpected", 64'd1, 64'd0);
        end else begin
          swap_t e;
          e = sb_q.pop_front();
          check("swap_rd_idx", 64'(rd_idx), 64'(e.idx));
          check("swap_rd_addr", 64'(rd_base_addr), 64'(e.addr));
          check("swap_valid", 64'(rd_frame_valid), 64'd1);
        end
      end
      prev_swap <= swap_pulse;
    end
  end

  // Raise the chosen inputs together, hold two cycles, then allow the
  // synchroniser and update to complete.
  task automatic pulse_inputs(input bit fd, input bit vs);
    @(negedge clk_100Mhz);
    frame_done = fd;
    rd_vsync   = vs;
    repeat (2) @(negedge clk_100Mhz);
    frame_done = 1'b0;
    rd_vsync   = 1'b0;
    repeat (5) @(negedge clk_100Mhz);
  endtask

  initial begin
    // Reset, asserted mid-cycle
    #3 rst = 1'b1;
    repeat (2) @(negedge clk_100Mhz);
    check("rst_wr_addr", 64'(wr_base_addr), 64'h0100_0000);
    check("rst_rd_addr", 64'(rd_base_addr), 64'h0120_0000);
    check("rst_state", 64'(state), 64'd0);
    check("rst_valid", 64'(rd_frame_valid), 64'd0);
    check("rst_idx", 64'({wr_idx, rd_idx}), 64'({2'd0, 2'd2}));
    rst = 1'b0;

    // Enable with no frame yet -> FILL; vsync is ignored there
    @(negedge clk_100Mhz);
    enable = 1'b1;
    repeat (2) @(negedge clk_100Mhz);
    check("fill_state", 64'(state), 64'd1);
    pulse_inputs(1'b0, 1'b1);
    check("fill_rd_idx", 64'(rd_idx), 64'd2);

    // First frame: w=1 l=0 r=2
    pulse_inputs(1'b1, 1'b0);
    check("first_state", 64'(state), 64'd2);
    check("first_wr_idx", 64'(wr_idx), 64'd1);
    check("first_wr_addr", 64'(wr_base_addr), 64'h0110_0000);
    check("first_frame_cnt", 64'(frame_cnt), 64'(cnt(1)));

    // Reader swap: r=0 l=2
    sb_q.push_back('{idx: 2'd0, addr: 32'h0100_0000});
    pulse_inputs(1'b0, 1'b1);
    check("swap_rd_idx_after", 64'(rd_idx), 64'd0);
    check("swap_valid_after", 64'(rd_frame_valid), 64'd1);

    // Second vsync without a new frame: no change, no pulse
    pulse_inputs(1'b0, 1'b1);
    check("reread_rd_idx", 64'(rd_idx), 64'd0);

    // Three frames, no reads: w=2 l=1 r=0, two drops, frames 1+3
    repeat (3) pulse_inputs(1'b1, 1'b0);
    check("drop_frame_cnt", 64'(frame_cnt), 64'(cnt(4)));
    check("drop_drop_cnt", 64'(drop_cnt), 64'(cnt(2)));
    check("drop_idx", 64'({wr_idx, rd_idx}), 64'({2'd2, 2'd0}));

    // Reader collects the last-written slot 1 -> w=2 l=0 r=1
    sb_q.push_back('{idx: 2'd1, addr: 32'h0110_0000});
    pulse_inputs(1'b0, 1'b1);

    // Simultaneous, no pending spare: r=2 w=0 l=1
    sb_q.push_back('{idx: 2'd2, addr: 32'h0120_0000});
    pulse_inputs(1'b1, 1'b1);
    check("sim_idx", 64'({wr_idx, rd_idx}), 64'({2'd0, 2'd2}));
    check("sim_frame_cnt", 64'(frame_cnt), 64'(cnt(5)));
    check("sim_drop_cnt", 64'(drop_cnt), 64'(cnt(2)));

    // New frame (w=1 l=0, pending) then simultaneous: r=1 w=0 l=2, drop
    pulse_inputs(1'b1, 1'b0);
    sb_q.push_back('{idx: 2'd1, addr: 32'h0110_0000});
    pulse_inputs(1'b1, 1'b1);
    check("sim2_idx", 64'({wr_idx, rd_idx}), 64'({2'd0, 2'd1}));
    check("sim2_frame_cnt", 64'(frame_cnt), 64'(cnt(7)));
    check("sim2_drop_cnt", 64'(drop_cnt), 64'(cnt(3)));

    // Disable: IDLE and events ignored
    @(negedge clk_100Mhz);
    enable = 1'b0;
    repeat (2) @(negedge clk_100Mhz);
    check("idle_state", 64'(state), 64'd0);
    pulse_inputs(1'b1, 1'b1);
    check("idle_idx", 64'({wr_idx, rd_idx}), 64'({2'd0, 2'd1}));
    check("idle_frame_cnt", 64'(frame_cnt), 64'(cnt(7)));

    // Re-enable: rd_frame_valid set -> straight to RUN
    enable = 1'b1;
    repeat (2) @(negedge clk_100Mhz);
    check("reen_state", 64'(state), 64'd2);
    check("reen_idx", 64'({wr_idx, rd_idx}), 64'({2'd0, 2'd1}));

    // One more frame (w=2) then asynchronous reset inside a cycle
    pulse_inputs(1'b1, 1'b0);
    check("pre_rst_wr_idx", 64'(wr_idx), 64'd2);
    @(negedge clk_100Mhz);
    #2 rst = 1'b1;
    #1;
    check("arst_wr_addr", 64'(wr_base_addr), 64'h0100_0000);
    check("arst_rd_addr", 64'(rd_base_addr), 64'h0120_0000);
    check("arst_state", 64'(state), 64'd0);
    check("arst_valid", 64'(rd_frame_valid), 64'd0);
    check("arst_frame_cnt", 64'(frame_cnt), 64'd0);
    check("arst_drop_cnt", 64'(drop_cnt), 64'd0);
    repeat (2) @(negedge clk_100Mhz);
    rst = 1'b0;
    repeat (2) @(negedge clk_100Mhz);

    check("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
